// File: rtl/apb_ucpd_clk_pkg.sv
// ============================================================================
// Module   : apb_ucpd_clk_pkg
// Brief    : Shared defaults and run/stopped state encoding for the clock divider.
// Revision : 1.0
// ============================================================================
`default_nettype none

package apb_ucpd_clk_pkg;

  localparam int DIV_W_DEF   = 8;
  localparam int DIV_MIN_DEF = 2;

  localparam int ST_W = 1;
  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_STOP = 1'b0;
  localparam state_t ST_RUN  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/apb_ucpd_clk_phase.sv
// ============================================================================
// Module   : apb_ucpd_clk_phase
// Brief    : Posedge/negedge phase flops and the odd/even output select.
// Revision : 1.0
// ============================================================================
`default_nettype none

module apb_ucpd_clk_phase (
  input  logic clk_in,
  input  logic rst_n,
  input  logic i_p_nxt,
  input  logic i_odd,
  output logic o_clk_out
);

  logic r_p;
  logic r_n;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_p <= 1'b0;
    end else begin
      r_p <= i_p_nxt;
    end
  end

  // Half-cycle delayed copy of p stretches the high time by 0.5 for odd ratios.
  always_ff @(negedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_n <= 1'b0;
    end else begin
      r_n <= r_p;
    end
  end

  assign o_clk_out = i_odd ? (r_p | r_n) : r_p;

endmodule

`default_nettype wire

// File: rtl/apb_ucpd_clk_gen.sv
// ============================================================================
// Module   : apb_ucpd_clk_gen
// Brief    : Glitch-free 50% duty clock divider with boundary-aligned updates.
// Revision : 1.0
// ============================================================================
`default_nettype none

module apb_ucpd_clk_gen
  import apb_ucpd_clk_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DIV_MIN = DIV_MIN_DEF
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] divisor,
  input  logic             div_upd,
  output logic             clk_out,
  output logic             tick,
  output logic [DIV_W-1:0] div_act,
  output logic             upd_ack
);

  localparam logic [DIV_W-1:0] C_DIV_MIN = DIV_W'(DIV_MIN);
  localparam logic [DIV_W-1:0] C_ONE     = DIV_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_nxt;
  logic [DIV_W-1:0] r_shadow;
  logic [DIV_W-1:0] w_div_req;
  logic             r_pend;
  logic             w_pend_nxt;
  logic             r_ack;
  logic             w_ack_nxt;
  logic             w_bnd;
  logic             w_p_nxt;

  assign w_div_req = (divisor < C_DIV_MIN) ? C_DIV_MIN : divisor;
  assign w_bnd     = (r_state == ST_RUN) && (r_cnt == (r_div - C_ONE));

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_STOP;
      r_cnt    <= '0;
      r_div    <= C_DIV_MIN;
      r_shadow <= C_DIV_MIN;
      r_pend   <= 1'b0;
      r_ack    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_div   <= w_div_nxt;
      r_pend  <= w_pend_nxt;
      r_ack   <= w_ack_nxt;
      if (div_upd) begin
        r_shadow <= w_div_req;
      end
    end
  end

  // en and pending updates are only honoured at the period boundary while running.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_div_nxt   = r_div;
    w_pend_nxt  = r_pend | div_upd;
    w_ack_nxt   = 1'b0;
    case (r_state)
      ST_STOP: begin
        w_cnt_nxt = '0;
        if (div_upd) begin
          w_div_nxt  = w_div_req;
          w_pend_nxt = 1'b0;
          w_ack_nxt  = 1'b1;
        end else if (r_pend) begin
          w_div_nxt  = r_shadow;
          w_pend_nxt = 1'b0;
          w_ack_nxt  = 1'b1;
        end
        if (en) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_bnd) begin
          w_cnt_nxt = '0;
          if (!en) begin
            w_state_nxt = ST_STOP;
          end
          if (div_upd) begin
            w_div_nxt  = w_div_req;
            w_pend_nxt = 1'b0;
            w_ack_nxt  = 1'b1;
          end else if (r_pend) begin
            w_div_nxt  = r_shadow;
            w_pend_nxt = 1'b0;
            w_ack_nxt  = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_STOP;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // p is registered from next-state values so it lines up with cnt and div_act.
  always_comb begin
    tick    = (r_state == ST_RUN) && (r_cnt == '0);
    w_p_nxt = (w_state_nxt == ST_RUN) && (w_cnt_nxt < (w_div_nxt >> 1));
  end

  assign div_act = r_div;
  assign upd_ack = r_ack;

  apb_ucpd_clk_phase u_phase (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .i_p_nxt   (w_p_nxt),
    .i_odd     (r_div[0]),
    .o_clk_out (clk_out)
  );

endmodule

`default_nettype wire
